// File: rtl/router_pkg.sv
// Shared constants and tx FSM encoding for the router1x3 packet source.
package router_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_LEN = 63;
    localparam int LEN_W       = 6;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_ERR_WAIT
    } tx_state_e;

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for router_pkt_tx: synchronous write, asynchronous read.
module router_tx_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 63,
    parameter int AW    = 6
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; every byte is written in LOAD before it is read.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for router1x3: load payload, send header/payload/parity, sample err.
// Optional macro ROUTER_PKT_TX_PARITY_CORRUPT_EN adds corrupt_par for parity error injection.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int ERR_WAIT = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [5:0]       pld_len,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             busy,
    input  logic             err,
    output logic [WIDTH-1:0] data_out,
    output logic             pkt_valid,
    output logic             tx_active,
    output logic             done,
    output logic             pkt_err,
    output logic             reject
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    ,
    input  logic             corrupt_par
`endif
);

    localparam int WW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] hdr_q, hdr_d, hdr_new;
    logic [WIDTH-1:0] par_q, par_d, par_tx;
    logic [LEN_W-1:0] cnt_q, cnt_d, idx_q, idx_d, rd_addr, last_idx;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic             done_q, done_d, pkt_err_q, pkt_err_d, reject_q, reject_d;
    logic             corrupt_q, corrupt_d;
    logic             buf_we;
    logic [WIDTH-1:0] buf_rdata;

    router_tx_buf #(.WIDTH(WIDTH), .DEPTH(MAX_LEN), .AW(LEN_W)) u_buf (
        .clock   (clock),
        .we_i    (buf_we),
        .waddr_i (cnt_q),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (buf_rdata)
    );

    assign last_idx = hdr_q[LEN_MSB:LEN_LSB] - 6'd1;
    assign par_tx   = par_q ^ {{(WIDTH-1){1'b0}}, corrupt_q};

    always_comb begin
        hdr_new = '0;
        hdr_new[LEN_MSB:LEN_LSB]   = pld_len;
        hdr_new[ADDR_MSB:ADDR_LSB] = dest_addr;
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        pkt_err_d   = pkt_err_q;
        corrupt_d   = corrupt_q;
        done_d      = 1'b0;
        reject_d    = 1'b0;
        buf_we      = 1'b0;
        // Next byte to present: entry 0 when leaving HEADER, otherwise the one after idx.
        rd_addr     = (state_q == S_HEADER) ? '0 : idx_q + 6'd1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dest_addr == ADDR_INVALID || pld_len == 6'd0) begin
                        reject_d = 1'b1;
                    end else begin
                        hdr_d     = hdr_new;
                        par_d     = hdr_new;
                        pkt_err_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = S_LOAD;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
                        corrupt_d = corrupt_par;
`else
                        corrupt_d = 1'b0;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    buf_we = 1'b1;
                    par_d  = par_q ^ wr_data;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == last_idx) begin
                        state_d     = S_HEADER;
                        data_out_d  = hdr_q;
                        pkt_valid_d = 1'b1;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    state_d    = S_PAYLOAD;
                    idx_d      = '0;
                    data_out_d = buf_rdata;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (idx_q == last_idx) begin
                        state_d     = S_PARITY;
                        data_out_d  = par_tx;
                        pkt_valid_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + 6'd1;
                        data_out_d = buf_rdata;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d    = S_ERR_WAIT;
                    wcnt_d     = '0;
                    data_out_d = '0;
                end
            end
            S_ERR_WAIT: begin
                pkt_err_d = pkt_err_q | err;
                // done lands in the first IDLE cycle, when pkt_err already includes the last sample.
                if (wcnt_q == WW'(ERR_WAIT - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            par_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pkt_err_q   <= 1'b0;
            reject_q    <= 1'b0;
            corrupt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            pkt_err_q   <= pkt_err_d;
            reject_q    <= reject_d;
            corrupt_q   <= corrupt_d;
        end
    end

    assign wr_ready  = (state_q == S_LOAD);
    assign tx_active = (state_q != S_IDLE);
    assign data_out  = data_out_q;
    assign pkt_valid = pkt_valid_q;
    assign done      = done_q;
    assign pkt_err   = pkt_err_q;
    assign reject    = reject_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed table, hand sequences, randomized packets.
module tb_router_pkt_tx;

    localparam int ERR_WAIT = 3;

    logic       clock = 1'b0;
    logic       resetn, start, wr_en, busy, err, corrupt_par;
    logic [1:0] dest_addr;
    logic [5:0] pld_len;
    logic [7:0] wr_data;
    logic       wr_ready, pkt_valid, tx_active, done, pkt_err, reject;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pl [63];

    router_pkt_tx #(.WIDTH(8), .MAX_LEN(63), .ERR_WAIT(ERR_WAIT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .dest_addr (dest_addr),
        .pld_len   (pld_len),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .err       (err),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_active (tx_active),
        .done      (done),
        .pkt_err   (pkt_err),
        .reject    (reject)
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        ,
        .corrupt_par (corrupt_par)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] a;
        logic [5:0] l;
        int         pmode;
        int         stall_k;
        int         stall_n;
        int         busy_pct;
        logic [2:0] err_pat;
        int         rst_at;
        logic [7:0] hdr;
        logic [7:0] par;
        logic       perr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void fill_pl(input int pmode, input int l);
        for (int i = 0; i < l; i++) begin
            case (pmode)
                0:       pl[i] = 8'((i + 1) * 17);
                1:       pl[i] = 8'(i);
                default: pl[i] = 8'($urandom);
            endcase
        end
    endfunction

    // Reference parity: header XOR every payload byte.
    function automatic logic [7:0] model_par(input logic [1:0] a, input logic [5:0] l);
        logic [7:0] p;
        p = {l, a};
        for (int i = 0; i < l; i++) p ^= pl[i];
        return p;
    endfunction

    task automatic send_pkt(input string nm, input logic [1:0] a, input logic [5:0] l,
                            input int stall_k, input int stall_n, input int busy_pct,
                            input logic [2:0] err_pat, input logic corrupt, input int rst_at,
                            input logic [7:0] exp_hdr, input logic [7:0] exp_par,
                            input logic exp_perr);
        int         w, k, stalled, guard;
        logic       b;
        logic [7:0] exp_b;
        @(negedge clock);
        start = 1'b1; dest_addr = a; pld_len = l; corrupt_par = corrupt;
        @(negedge clock);
        start = 1'b0; dest_addr = 2'($urandom); pld_len = 6'($urandom);
        check({nm, "_load_ready"}, wr_ready, 1);
        check({nm, "_load_active"}, tx_active, 1);
        check({nm, "_perr_clr"}, pkt_err, 0);
        w = 0; guard = 0;
        while (w < l) begin
            wr_en   = (guard > 200) || ($urandom_range(0, 99) < 70);
            wr_data = wr_en ? pl[w] : 8'($urandom);
            busy    = 1'($urandom);
            guard++;
            @(negedge clock);
            if (wr_en) w++;
        end
        k = 0; stalled = 0; guard = 0;
        while (k <= l + 1) begin
            exp_b = (k == 0) ? exp_hdr : (k <= l) ? pl[k-1] : exp_par;
            check($sformatf("%s_b%0d_data", nm, k), data_out, exp_b);
            check($sformatf("%s_b%0d_valid", nm, k), pkt_valid, (k <= l));
            check($sformatf("%s_b%0d_active", nm, k), tx_active, 1);
            check($sformatf("%s_b%0d_wrrdy", nm, k), wr_ready, 0);
            if (rst_at == k) begin
                resetn = 1'b0;
                @(negedge clock);
                check({nm, "_rst_valid"}, pkt_valid, 0);
                check({nm, "_rst_data"}, data_out, 0);
                check({nm, "_rst_active"}, tx_active, 0);
                check({nm, "_rst_done"}, done, 0);
                resetn = 1'b1; wr_en = 1'b0; start = 1'b0; busy = 1'b0;
                return;
            end
            if (k == stall_k && stalled < stall_n) begin
                b = 1'b1;
                stalled++;
            end else begin
                b = ($urandom_range(0, 99) < busy_pct) && (guard < 2000);
            end
            busy = b;
            wr_en = 1'($urandom); wr_data = 8'($urandom); start = 1'($urandom);
            guard++;
            @(negedge clock);
            if (!b) k++;
        end
        busy = 1'b0; start = 1'b0; wr_en = 1'b0;
        for (int j = 0; j < ERR_WAIT; j++) begin
            check($sformatf("%s_ew%0d_valid", nm, j), pkt_valid, 0);
            check($sformatf("%s_ew%0d_data", nm, j), data_out, 0);
            check($sformatf("%s_ew%0d_active", nm, j), tx_active, 1);
            check($sformatf("%s_ew%0d_done", nm, j), done, 0);
            err = err_pat[j];
            @(negedge clock);
        end
        err = 1'b0;
        check({nm, "_done"}, done, 1);
        check({nm, "_idle"}, tx_active, 0);
        check({nm, "_pkt_err"}, pkt_err, exp_perr);
        @(negedge clock);
        check({nm, "_done_pulse"}, done, 0);
        check({nm, "_pkt_err_hold"}, pkt_err, exp_perr);
    endtask

    task automatic bad_start(input string nm, input logic [1:0] a, input logic [5:0] l,
                             input logic exp_perr);
        @(negedge clock);
        start = 1'b1; dest_addr = a; pld_len = l; wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clock);
        start = 1'b0;
        check({nm, "_reject"}, reject, 1);
        check({nm, "_active"}, tx_active, 0);
        check({nm, "_wrrdy"}, wr_ready, 0);
        check({nm, "_valid"}, pkt_valid, 0);
        check({nm, "_perr_hold"}, pkt_err, exp_perr);
        @(negedge clock);
        wr_en = 1'b0;
        check({nm, "_reject_pulse"}, reject, 0);
        check({nm, "_still_idle"}, tx_active, 0);
    endtask

    initial begin
        logic [1:0] ra;
        logic [5:0] rl;
        logic [2:0] re;

        //          a   l    pm stk stn bsy err     rst  hdr    par    perr
        vecs[0] = '{2'd1, 6'd3,  0, -1, 0, 0, 3'b000, -1, 8'h0D, 8'h0D, 1'b0};
        vecs[1] = '{2'd1, 6'd3,  0,  2, 4, 0, 3'b000, -1, 8'h0D, 8'h0D, 1'b0};
        vecs[2] = '{2'd2, 6'd63, 1, -1, 0, 0, 3'b000, -1, 8'hFE, 8'hC1, 1'b0};
        vecs[3] = '{2'd1, 6'd10, 1, -1, 0, 0, 3'b000,  5, 8'h29, 8'h28, 1'b0};
        vecs[4] = '{2'd0, 6'd1,  0,  0, 2, 0, 3'b010, -1, 8'h04, 8'h15, 1'b1};

        resetn = 1'b0; start = 1'b0; dest_addr = '0; pld_len = '0; wr_en = 1'b0;
        wr_data = '0; busy = 1'b0; err = 1'b0; corrupt_par = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_data", data_out, 0);
        check("rst_valid", pkt_valid, 0);
        check("rst_wrrdy", wr_ready, 0);
        check("rst_active", tx_active, 0);
        check("rst_done", done, 0);
        check("rst_pkt_err", pkt_err, 0);
        check("rst_reject", reject, 0);
        resetn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill_pl(vecs[v].pmode, vecs[v].l);
            send_pkt($sformatf("vec%0d", v), vecs[v].a, vecs[v].l, vecs[v].stall_k,
                     vecs[v].stall_n, vecs[v].busy_pct, vecs[v].err_pat, 1'b0,
                     vecs[v].rst_at, vecs[v].hdr, vecs[v].par, vecs[v].perr);
        end

        bad_start("rej_addr3", 2'd3, 6'd5, 1'b1);
        bad_start("rej_len0", 2'd1, 6'd0, 1'b1);

        for (int r = 0; r < 20; r++) begin
            ra = 2'($urandom_range(0, 2));
            rl = (r == 7) ? 6'd63 : 6'($urandom_range(1, 20));
            re = 3'($urandom);
            fill_pl(2, rl);
            send_pkt($sformatf("rnd%0d", r), ra, rl, -1, 0, 30, re, 1'b0, -1,
                     {rl, ra}, model_par(ra, rl), |re);
        end

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        fill_pl(0, 3);
        send_pkt("corrupt", 2'd1, 6'd3, -1, 0, 0, 3'b111, 1'b1, -1, 8'h0D, 8'h0C, 1'b1);
        bad_start("corrupt_rej", 2'd3, 6'd2, 1'b1);
        send_pkt("corrupt_off", 2'd1, 6'd3, -1, 0, 0, 3'b000, 1'b0, -1, 8'h0D, 8'h0D, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
